// File: rtl/sort_pkg.sv
// Shared types and constants for the in-place memory sort engine.
package sort_pkg;

  // Byte distance between consecutive words in data memory.
  localparam int unsigned WORD_STRIDE = 4;

  typedef enum logic [3:0] {
    IDLE,
    RD_A,
    RD_B,
    CAP_B,
    CMP,
    WR_A,
    WR_B,
    ADV,
    FIN
  } sort_state_t;

endpackage

// File: rtl/sort_cmp.sv
// Compare stage: decides whether the adjacent pair A (lower address) and
// B (higher address) must be exchanged. Equal words never swap.
module sort_cmp #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              descending,
  input  logic              signed_cmp,
  output logic              do_swap
);

  logic a_gt_b;
  logic a_lt_b;

  // Strict ordering in the selected number system, then pick by direction.
  always_comb begin
    a_gt_b = 1'b0;
    a_lt_b = 1'b0;
    if (signed_cmp) begin
      a_gt_b = $signed(a) > $signed(b);
      a_lt_b = $signed(a) < $signed(b);
    end else begin
      a_gt_b = a > b;
      a_lt_b = a < b;
    end
    do_swap = descending ? a_lt_b : a_gt_b;
  end

endmodule

// File: rtl/mem_sort_engine.sv
// Bubble sort with early exit over COUNT consecutive words in data memory,
// acting as a second master on a synchronous single-port RAM interface.
module mem_sort_engine
  import sort_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 32,
  parameter  int MAX_N  = 16,
  localparam int CNT_W  = $clog2(MAX_N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              descending,
  input  logic              signed_cmp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       swap_count
);

  sort_state_t       state;
  logic [ADDR_W-1:0] base_r;
  logic              desc_r;
  logic              sgn_r;
  logic              bad_r;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  last;
  logic              swapped;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic              do_swap;
  logic [CNT_W-1:0]  idx_nxt;

  assign idx_nxt = idx + CNT_W'(1);

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  k);
    return base + ADDR_W'(k) * ADDR_W'(WORD_STRIDE);
  endfunction

  sort_cmp #(.DATA_W(DATA_W)) u_cmp (
    .a          (a_r),
    .b          (b_r),
    .descending (desc_r),
    .signed_cmp (sgn_r),
    .do_swap    (do_swap)
  );

  // Sequencer. Memory strobes/address are loaded on the transition into the
  // state that owns the access, so each strobe is high during that state only.
  // done is raised from FIN, i.e. on the cycle the engine is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base_r     <= '0;
      desc_r     <= 1'b0;
      sgn_r      <= 1'b0;
      bad_r      <= 1'b0;
      idx        <= '0;
      last       <= '0;
      swapped    <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      mem_addr   <= '0;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      swap_count <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_r     <= base_addr;
            desc_r     <= descending;
            sgn_r      <= signed_cmp;
            swap_count <= '0;
            err        <= 1'b0;
            bad_r      <= 1'b0;
            busy       <= 1'b1;
            if (count > CNT_W'(MAX_N)) begin
              bad_r <= 1'b1;
              state <= FIN;
            end else if (count < CNT_W'(2)) begin
              state <= FIN;
            end else begin
              idx       <= '0;
              last      <= count - CNT_W'(1);
              swapped   <= 1'b0;
              mem_addr  <= base_addr;
              mem_rd_en <= 1'b1;
              state     <= RD_A;
            end
          end
        end
        RD_A: begin
          mem_addr  <= word_addr(base_r, idx_nxt);
          mem_rd_en <= 1'b1;
          state     <= RD_B;
        end
        RD_B: begin
          a_r   <= mem_rdata;
          state <= CAP_B;
        end
        CAP_B: begin
          b_r   <= mem_rdata;
          state <= CMP;
        end
        CMP: begin
          if (do_swap) begin
            mem_addr  <= word_addr(base_r, idx);
            mem_wdata <= b_r;
            mem_wr_en <= 1'b1;
            state     <= WR_A;
          end else begin
            state <= ADV;
          end
        end
        WR_A: begin
          mem_addr  <= word_addr(base_r, idx_nxt);
          mem_wdata <= a_r;
          mem_wr_en <= 1'b1;
          state     <= WR_B;
        end
        WR_B: begin
          if (swap_count != 16'hFFFF) swap_count <= swap_count + 16'd1;
          swapped <= 1'b1;
          state   <= ADV;
        end
        ADV: begin
          if (idx_nxt < last) begin
            idx       <= idx_nxt;
            mem_addr  <= word_addr(base_r, idx_nxt);
            mem_rd_en <= 1'b1;
            state     <= RD_A;
          end else if (!swapped || last == CNT_W'(1)) begin
            state <= FIN;
          end else begin
            last      <= last - CNT_W'(1);
            idx       <= '0;
            swapped   <= 1'b0;
            mem_addr  <= base_r;
            mem_rd_en <= 1'b1;
            state     <= RD_A;
          end
        end
        FIN: begin
          done  <= 1'b1;
          err   <= bad_r;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sort_engine.sv
// Directed bench for mem_sort_engine with a 256-byte synchronous RAM model.
module tb_mem_sort_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [4:0]  count;
  logic        descending;
  logic        signed_cmp;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] swap_count;

  logic [31:0] ram [64];
  logic        ld_en;
  logic [5:0]  ld_idx;
  logic [31:0] ld_data;
  int          rd_cnt;
  int          wr_cnt;
  logic        both_hi;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_sort_engine #(.DATA_W(32), .ADDR_W(32), .MAX_N(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .count      (count),
    .descending (descending),
    .signed_cmp (signed_cmp),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rdata  (mem_rdata),
    .mem_wr_en  (mem_wr_en),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .swap_count (swap_count)
  );

  initial begin
    rd_cnt  = 0;
    wr_cnt  = 0;
    both_hi = 1'b0;
  end

  // RAM model plus strobe monitors; the bench loads words through ld_*.
  always @(posedge clk) begin
    if (ld_en) ram[ld_idx] <= ld_data;
    if (mem_wr_en) ram[mem_addr[7:2]] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= ram[mem_addr[7:2]];
    if (mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (mem_wr_en) wr_cnt <= wr_cnt + 1;
    if (mem_rd_en && mem_wr_en) both_hi <= 1'b1;
  end

  typedef struct packed {
    logic [4:0]        cnt;
    logic              desc;
    logic              sgn;
    logic [7:0]        base;
    logic [0:7][31:0]  din;
    logic [0:7][31:0]  dexp;
    logic [15:0]       swaps;
    logic [15:0]       cyc;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic ram_put(input logic [5:0] idx, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_idx  = idx;
    ld_data = d;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  // Pulses start, then counts cycles until done. If poke is nonzero a second
  // start (different base/count) is offered at that cycle while busy.
  task automatic run_sort(input logic [7:0] base, input logic [4:0] cnt, input logic d,
                          input logic s, input int poke,
                          output int cyc, output int rds, output int wrs);
    int r0, w0;
    @(negedge clk);
    base_addr  = {24'd0, base};
    count      = cnt;
    descending = d;
    signed_cmp = s;
    start      = 1'b1;
    r0 = rd_cnt;
    w0 = wr_cnt;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done || cyc >= 5000) break;
      if (poke != 0 && cyc == poke) begin
        base_addr = 32'd0;
        count     = 5'd2;
        start     = 1'b1;
      end
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    rds = rd_cnt - r0;
    wrs = wr_cnt - w0;
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cyc, rds, wrs;
    logic [5:0] w0;

    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
    descending = 1'b0; signed_cmp = 1'b0;
    ld_en = 1'b0; ld_idx = '0; ld_data = '0;

    vecs[0] = '{5'd2, 1'b0, 1'b0, 8'h00,
                {32'd10, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                {32'd5, 32'd10, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 16'd1, 16'd9};
    vecs[1] = '{5'd4, 1'b0, 1'b0, 8'h20,
                {32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0},
                {32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0}, 16'd0, 16'd17};
    vecs[2] = '{5'd8, 1'b0, 1'b0, 8'h40,
                {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1},
                {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8}, 16'd28, 16'd198};
    vecs[3] = '{5'd3, 1'b1, 1'b1, 8'h80,
                {32'hFFFFFFFD, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                {32'd7, 32'd0, 32'hFFFFFFFD, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 16'd2, 16'd21};
    vecs[4] = '{5'd3, 1'b0, 1'b0, 8'h80,
                {32'hFFFFFFFD, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                {32'd0, 32'd7, 32'hFFFFFFFD, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 16'd3, 16'd23};
    vecs[5] = '{5'd3, 1'b0, 1'b1, 8'hA0,
                {32'd3, 32'd3, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                {32'd1, 32'd3, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 16'd2, 16'd21};

    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("rst_swap_count", {16'd0, swap_count}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      w0 = vecs[v].base[7:2];
      for (int k = 0; k < int'(vecs[v].cnt); k++)
        ram_put(w0 + 6'(k), vecs[v].din[k]);
      ram_put(w0 + 6'(vecs[v].cnt), 32'hDEADBEEF);
      run_sort(vecs[v].base, vecs[v].cnt, vecs[v].desc, vecs[v].sgn, 0, cyc, rds, wrs);
      for (int k = 0; k < int'(vecs[v].cnt); k++)
        check($sformatf("v%0d_word%0d", v, k), ram[w0 + 6'(k)], vecs[v].dexp[k]);
      check($sformatf("v%0d_guard", v), ram[w0 + 6'(vecs[v].cnt)], 32'hDEADBEEF);
      check($sformatf("v%0d_swaps", v), {16'd0, swap_count}, {16'd0, vecs[v].swaps});
      check($sformatf("v%0d_err", v), {31'd0, err}, 32'd0);
      check($sformatf("v%0d_cycles", v), cyc, {16'd0, vecs[v].cyc});
      check($sformatf("v%0d_writes", v), wrs, 2 * int'(vecs[v].swaps));
    end

    // count=1: immediate completion, no memory traffic.
    run_sort(8'h00, 5'd1, 1'b0, 1'b0, 0, cyc, rds, wrs);
    check("n1_cycles", cyc, 2);
    check("n1_reads", rds, 0);
    check("n1_err", {31'd0, err}, 32'd0);

    // count=MAX_N+1: error, no memory traffic.
    run_sort(8'h00, 5'd17, 1'b0, 1'b0, 0, cyc, rds, wrs);
    check("ovf_err", {31'd0, err}, 32'd1);
    check("ovf_cycles", cyc, 2);
    check("ovf_access", rds + wrs, 0);
    check("ovf_swaps", {16'd0, swap_count}, 32'd0);

    // Start while busy is ignored; err from the previous run is cleared.
    for (int k = 0; k < 4; k++) ram_put(6'd16 + 6'(k), 32'(4 - k));
    ram_put(6'd0, 32'd9);
    ram_put(6'd1, 32'd2);
    run_sort(8'h40, 5'd4, 1'b0, 1'b0, 5, cyc, rds, wrs);
    for (int k = 0; k < 4; k++)
      check($sformatf("busy_word%0d", k), ram[6'd16 + 6'(k)], 32'(k + 1));
    check("busy_untouched0", ram[0], 32'd9);
    check("busy_untouched1", ram[1], 32'd2);
    check("busy_cycles", cyc, 44);
    check("busy_swaps", {16'd0, swap_count}, 32'd6);
    check("busy_err_cleared", {31'd0, err}, 32'd0);
    repeat (4) @(negedge clk);
    check("busy_no_restart", {31'd0, busy}, 32'd0);

    // Reset on the first WR_A cycle of an 8-word reverse sort, then rerun.
    for (int k = 0; k < 8; k++) ram_put(6'd16 + 6'(k), 32'(8 - k));
    @(negedge clk);
    base_addr = 32'h40; count = 5'd8; descending = 1'b0; signed_cmp = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!mem_wr_en && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("wr_a_reached", {31'd0, mem_wr_en}, 32'd1);
    check("wr_a_addr", mem_addr, 32'h40);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("midrst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("midrst_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_word0_kept", ram[16], 32'd8);
    run_sort(8'h40, 5'd8, 1'b0, 1'b0, 0, cyc, rds, wrs);
    for (int k = 0; k < 8; k++)
      check($sformatf("rerun_word%0d", k), ram[6'd16 + 6'(k)], 32'(k + 1));
    check("rerun_swaps", {16'd0, swap_count}, 32'd28);

    check("strobes_exclusive", {31'd0, both_hi}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
